kan_layer_sequencer: RTL and testbench
======================================

Name: kan_layer_sequencer

Overview:
Time-multiplexed controller for one KAN linear layer. It walks every (out, in) weight pair through a single shared multiplier, accumulating one output neuron at a time from an external weight ROM. Each finished neuron is streamed out with a valid/ready handshake. It sits between the layer input register and the next layer, replacing a fully parallel multiply array.

Parameters:
IN_FEATURES, 2, inputs per neuron (>=1)
OUT_FEATURES, 3, output neurons (>=1)
ADDR_W, 8, weight ROM address width; must satisfy 2^ADDR_W >= IN_FEATURES*OUT_FEATURES
FRAC_W, 8, fractional bits of signed Q(16-FRAC_W).FRAC_W data and weights

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to run the layer; ignored unless idle
data_in  in  16*IN_FEATURES  signed input vector, element j at bits [16j+15:16j]; latched on accepted start
busy  out  1  high from accepted start until done
w_addr  out  ADDR_W  weight ROM address = i*IN_FEATURES + j
w_rd  out  1  ROM read strobe
w_data  in  16  signed weight; valid exactly 1 cycle after w_rd
out_valid  out  1  out_data/out_idx valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_data  out  16  neuron result
out_idx  out  clog2(OUT_FEATURES)+1  neuron index i
done  out  1  one-cycle pulse after the last neuron is accepted

Behaviour:
- Reset: FSM=IDLE, busy=0, w_rd=0, w_addr=0, out_valid=0, out_data=0, out_idx=0, done=0, accumulator=0, counters=0.
- States are IDLE, FETCH, DRAIN, EMIT, FIN.
- IDLE: start=1 latches data_in, clears i, j and acc, then moves to FETCH. busy rises the next cycle.
- FETCH: w_rd=1 and w_addr=i*IN+j every cycle. j increments. When j=IN-1, go to DRAIN.
- MAC pipeline: the cycle after each w_rd, acc += sext(w_data)*sext(x[j_d]), where j_d is j delayed by one cycle. The product is 32-bit and acc is 32+clog2(IN) bits, signed, with no wrap.
- DRAIN: w_rd=0. The final MAC completes. The result register gets sat16(acc >>> FRAC_W), with arithmetic shift and truncation toward -inf. Saturation limits are 0x7FFF and 0x8000. Then out_valid=1, out_idx=i, go to EMIT.
- EMIT: out_data/out_idx are held stable while out_valid && !out_ready, and no ROM access happens. On the handshake, out_valid drops that same edge. If i=OUT-1, go to FIN. Otherwise i++, j=0, acc=0, go to FETCH.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency with out_ready tied high: start to first out_valid = IN+2 cycles. Each further neuron takes IN+2 cycles. done asserts OUT*(IN+2)+1 cycles after start.
- start while busy is ignored. data_in changes after the latch have no effect.
- Reset mid-operation aborts immediately to the reset state. There is no partial output and no done pulse.
- Boundary: IN_FEATURES=1 gives a single FETCH cycle per neuron. w_addr never exceeds IN*OUT-1.

Optional Feature:
KAN_SEQ_RELU_EN
- Defined: after saturation, a negative result is clamped to 0x0000 before out_data is registered.
- Undefined: the signed saturated result passes unchanged.
- Timing is identical in both cases.

Decomposition:
- Package kan_pkg holds:
  - DATA_W=16 and default FRAC_W
  - the state enum for the sequencer
  - the sat16 function (wide signed to 16-bit clamp)
  - the address-width helper function
- One sub-module, kan_mac_unit: registered 16x16 signed multiply-accumulate with clear, enable and a saturated/shifted result output.
- The FSM, counters and handshake stay in kan_layer_sequencer.

Test Plan:
All values Q8.8, IN=2, OUT=3.
- Basic: x={0x0100,0x0200}, row0 w={0x0100,0x0100} -> out_idx=0, out_data=0x0300, out_valid first high 4 cycles after start.
- Negative: row1 w={0xFF00,0x0000} -> out_data=0xFF00 without KAN_SEQ_RELU_EN, 0x0000 with it.
- Saturation: x={0x7F00,0x7F00}, row2 w={0x7F00,0x7F00} -> out_data=0x7FFF. Check w={0x8100,0x8100} with positive x -> 0x8000 (0x0000 if RELU).
- Backpressure: hold out_ready=0 for 5 cycles on neuron 1 -> out_valid, out_data and out_idx stable, w_rd=0 throughout. Release -> neuron 2 fetch starts next cycle. done arrives 5 cycles later than the 13-cycle baseline.
- Protocol: pulse start again while busy, with data_in changed -> results unchanged and exactly 3 outputs, then a single done pulse.
- Reset mid-run: assert reset during neuron 1 FETCH -> all outputs 0 same cycle. A new start produces a full correct 3-neuron sequence.

Source files
------------

// File: rtl/kan_pkg.sv
// Shared types and helpers for the KAN layer sequencer and its MAC unit.
// Holds the data width, default fraction width, FSM states, saturation and width helpers.
package kan_pkg;

    localparam int DATA_W     = 16;
    localparam int FRAC_W_DEF = 8;
    localparam int SAT_IN_W   = 48;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_FIN   = 3'd4
    } seq_state_t;

    // Clamp a wide signed value into the signed 16-bit range.
    function automatic logic [DATA_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] v);
        logic [DATA_W-1:0] r;
        if (v > 48'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -48'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    function automatic int kan_addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/kan_mac_unit.sv
// Registered 16x16 signed multiply-accumulate with clear, enable and a shifted, saturated result.
// With KAN_SEQ_RELU_EN defined, negative results are clamped to zero before being registered.
module kan_mac_unit
    import kan_pkg::*;
#(
    parameter int ACC_W  = 33,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_w,
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_result
);

    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_shift;
    logic [DATA_W-1:0]       w_sat;
    logic [DATA_W-1:0]       w_res;
    logic signed [ACC_W-1:0] r_acc;
    logic [DATA_W-1:0]       r_result;

    // The load path folds in the in-flight product so the final term is not lost.
    always_comb begin
        w_prod = $signed({{16{i_w[15]}}, i_w}) * $signed({{16{i_x[15]}}, i_x});
        if (i_en) begin
            w_sum = r_acc + ACC_W'(w_prod);
        end else begin
            w_sum = r_acc;
        end
        w_shift = w_sum >>> FRAC_W;
        w_sat   = sat16(SAT_IN_W'(w_shift));
`ifdef KAN_SEQ_RELU_EN
        w_res   = w_sat[DATA_W-1] ? 16'h0000 : w_sat;
`else
        w_res   = w_sat;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_result <= 16'h0000;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= w_sum;
            end
            if (i_load) begin
                r_result <= w_res;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/kan_layer_sequencer.sv
// Time-multiplexed KAN linear layer: one shared MAC walks every (out, in) weight pair.
// Optional ReLU on each neuron result is enabled by defining KAN_SEQ_RELU_EN.
module kan_layer_sequencer
    import kan_pkg::*;
#(
    parameter int IN_FEATURES  = 2,
    parameter int OUT_FEATURES = 3,
    parameter int ADDR_W       = 8,
    parameter int FRAC_W       = FRAC_W_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [DATA_W*IN_FEATURES-1:0]   data_in,
    output logic                            busy,
    output logic [ADDR_W-1:0]               w_addr,
    output logic                            w_rd,
    input  logic [DATA_W-1:0]               w_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [$clog2(OUT_FEATURES):0]   out_idx,
    output logic                            done
);

    localparam int IDX_W = $clog2(OUT_FEATURES) + 1;
    localparam int J_W   = kan_addr_w(IN_FEATURES);
    localparam int ACC_W = 32 + $clog2(IN_FEATURES);
    localparam logic [J_W-1:0]   J_LAST = J_W'(IN_FEATURES - 1);
    localparam logic [IDX_W-1:0] I_LAST = IDX_W'(OUT_FEATURES - 1);

    seq_state_t        r_state;
    logic [IDX_W-1:0]  r_i;
    logic [J_W-1:0]    r_j;
    logic [J_W-1:0]    r_j_d;
    logic              r_rd_d;
    logic [DATA_W-1:0] r_x [IN_FEATURES];
    logic              r_busy;
    logic              r_w_rd;
    logic [ADDR_W-1:0] r_w_addr;
    logic              r_out_valid;
    logic [IDX_W-1:0]  r_out_idx;
    logic              r_done;

    logic              w_hs;
    logic              w_mac_clear;
    logic              w_mac_load;
    logic [DATA_W-1:0] w_x_sel;
    logic [DATA_W-1:0] w_result;

    always_comb begin
        w_hs        = r_out_valid && out_ready;
        w_mac_clear = (r_state == S_IDLE) || w_hs;
        w_mac_load  = (r_state == S_DRAIN);
        w_x_sel     = r_x[r_j_d];
    end

    kan_mac_unit #(
        .ACC_W  (ACC_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_mac_clear),
        .i_en     (r_rd_d),
        .i_load   (w_mac_load),
        .i_w      (w_data),
        .i_x      (w_x_sel),
        .o_result (w_result)
    );

    // Addresses are visited in row-major order, so the next address is always the previous plus one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_j_d       <= '0;
            r_rd_d      <= 1'b0;
            for (int k = 0; k < IN_FEATURES; k++) begin
                r_x[k] <= '0;
            end
            r_busy      <= 1'b0;
            r_w_rd      <= 1'b0;
            r_w_addr    <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_rd_d <= r_w_rd;
            r_j_d  <= r_j;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int k = 0; k < IN_FEATURES; k++) begin
                            r_x[k] <= data_in[DATA_W*k +: DATA_W];
                        end
                        r_i      <= '0;
                        r_j      <= '0;
                        r_busy   <= 1'b1;
                        r_w_rd   <= 1'b1;
                        r_w_addr <= '0;
                        r_state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_j == J_LAST) begin
                        r_w_rd  <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_j      <= r_j + J_W'(1);
                        r_w_addr <= r_w_addr + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    r_out_valid <= 1'b1;
                    r_out_idx   <= r_i;
                    r_state     <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        if (r_i == I_LAST) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_FIN;
                        end else begin
                            r_i      <= r_i + IDX_W'(1);
                            r_j      <= '0;
                            r_w_rd   <= 1'b1;
                            r_w_addr <= r_w_addr + ADDR_W'(1);
                            r_state  <= S_FETCH;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_w_rd      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign w_rd      = r_w_rd;
    assign w_addr    = r_w_addr;
    assign out_valid = r_out_valid;
    assign out_data  = w_result;
    assign out_idx   = r_out_idx;
    assign done      = r_done;

endmodule

// File: tb/tb_kan_layer_sequencer.sv
// Self-checking bench for kan_layer_sequencer (IN=2, OUT=3, Q8.8) against an arithmetic reference model.
module tb_kan_layer_sequencer;

    localparam int IN  = 2;
    localparam int OUT = 3;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   data_in;
    logic          busy;
    logic [AW-1:0] w_addr;
    logic          w_rd;
    logic [15:0]   w_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic [2:0]    out_idx;
    logic          done;

    logic [15:0] rom [0:255];
    logic [15:0] xv  [0:IN-1];
    int errors = 0;
    int checks = 0;

    kan_layer_sequencer #(
        .IN_FEATURES  (IN),
        .OUT_FEATURES (OUT),
        .ADDR_W       (AW),
        .FRAC_W       (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .busy      (busy),
        .w_addr    (w_addr),
        .w_rd      (w_rd),
        .w_data    (w_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Weight ROM with one cycle of read latency; junk on the bus when not read.
    always @(posedge clk) begin
        if (w_rd) w_data <= rom[w_addr];
        else      w_data <= 16'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Neuron i = floor(sum_j w[i][j]*x[j] / 256), clamped to int16 (and to >=0 with ReLU).
    function automatic logic [15:0] ref_neuron(input int i);
        longint s;
        longint q;
        s = 0;
        for (int j = 0; j < IN; j++)
            s += longint'($signed(rom[i*IN+j])) * longint'($signed(xv[j]));
        q = s / 256;
        if ((s % 256) != 0 && s < 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`ifdef KAN_SEQ_RELU_EN
        if (q < 0) q = 0;
`endif
        return q[15:0];
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      32'(busy), 32'd0);
        chk({tag, "_w_rd"},      32'(w_rd), 32'd0);
        chk({tag, "_w_addr"},    32'(w_addr), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data), 32'd0);
        chk({tag, "_out_idx"},   32'(out_idx), 32'd0);
        chk({tag, "_done"},      32'(done), 32'd0);
    endtask

    task automatic run_layer(input int stall_at, input int stall_len, input bit poke_start);
        logic [15:0] exp_d [0:OUT-1];
        logic [15:0] held_data;
        logic [2:0]  held_idx;
        int n_out, first_valid, done_cyc, n_done, stall_left, next_fetch;
        bit stalled;
        for (int i = 0; i < OUT; i++) exp_d[i] = ref_neuron(i);
        n_out = 0; first_valid = -1; done_cyc = -1; n_done = 0;
        stall_left = stall_len; next_fetch = -1; stalled = 1'b0;
        held_data = 16'h0000; held_idx = 3'd0;
        data_in   = {xv[1], xv[0]};
        out_ready = 1'b1;
        start     = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            start = (poke_start && c == 2);
            if (poke_start && c == 2) data_in = ~data_in;
            if (c == 1) chk("busy_rise", 32'(busy), 32'd1);
            if (next_fetch >= 0) begin
                chk("refetch_rd", 32'(w_rd), 32'd1);
                chk("refetch_addr", 32'(w_addr), 32'(next_fetch * IN));
                next_fetch = -1;
            end
            if (w_rd) chk("addr_range", 32'(w_addr < AW'(IN * OUT)), 32'd1);
            if (out_valid && first_valid < 0) first_valid = c;
            out_ready = 1'b1;
            if (out_valid && n_out == stall_at && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            if (out_valid && n_out == stall_at && stall_len > 0) begin
                if (!stalled) begin
                    held_data = out_data;
                    held_idx  = out_idx;
                    stalled   = 1'b1;
                end else begin
                    chk("stall_data", 32'(out_data), 32'(held_data));
                    chk("stall_idx", 32'(out_idx), 32'(held_idx));
                end
                if (!out_ready) chk("stall_no_rd", 32'(w_rd), 32'd0);
            end
            if (out_valid && out_ready) begin
                chk("out_idx", 32'(out_idx), 32'(n_out));
                if (n_out < OUT) chk("out_data", 32'(out_data), 32'(exp_d[n_out]));
                n_out++;
                if (n_out < OUT) next_fetch = n_out;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
                chk("busy_at_done", 32'(busy), 32'd0);
            end
            if (done_cyc > 0 && c >= done_cyc + 3) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("n_out", 32'(n_out), 32'(OUT));
        chk("first_valid", 32'(first_valid), 32'(IN + 2));
        chk("done_cycle", 32'(done_cyc), 32'(OUT * (IN + 2) + 1 + stall_len));
        chk("done_pulses", 32'(n_done), 32'd1);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        data_in   = 32'h0;
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Basic, negative and fractional rows; second start pulse while busy.
        xv[0] = 16'h0100; xv[1] = 16'h0200;
        rom[0] = 16'h0100; rom[1] = 16'h0100;
        rom[2] = 16'hFF00; rom[3] = 16'h0000;
        rom[4] = 16'h0080; rom[5] = 16'hFF80;
        run_layer(3, 0, 1'b1);

        // Saturation both ways, with backpressure on neuron 1.
        xv[0] = 16'h7F00; xv[1] = 16'h7F00;
        rom[0] = 16'h8100; rom[1] = 16'h8100;
        rom[2] = 16'h8000; rom[3] = 16'h0100;
        rom[4] = 16'h7F00; rom[5] = 16'h7F00;
        run_layer(1, 5, 1'b0);

        // Reset during neuron 1 fetch, then a full clean run.
        xv[0] = 16'($urandom); xv[1] = 16'($urandom);
        data_in = {xv[1], xv[0]};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_fetch_rd", 32'(w_rd), 32'd1);
        chk("mid_fetch_addr", 32'(w_addr), 32'd2);
        reset = 1'b1;
        #1;
        chk_all_zero("abort");
        @(negedge clk);
        chk("abort_no_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle_valid", 32'(out_valid), 32'd0);
        run_layer(3, 0, 1'b0);

        // Randomized layers: full-range or small Q8.8 values, random stall placement.
        for (int r = 0; r < 6; r++) begin
            for (int j = 0; j < IN; j++)
                xv[j] = (r % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
            for (int a = 0; a < IN * OUT; a++)
                rom[a] = (r % 3 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
            run_layer(int'($urandom_range(0, 2)), int'($urandom_range(0, 6)), r[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
